sub_serial16: RTL and testbench
===============================

SUB_SERIAL16 -- requirements
Module: sub_serial16

Interface
REQ-001 Parameter SLICE, default 4: bits processed per cycle; SHALL divide 16; NSLICE = 16/SLICE.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 ina  input  16  minuend, captured with start.
REQ-006 inb  input  16  subtrahend, captured with start.
REQ-007 bin  input  1  borrow-in, captured with start.
REQ-008 busy  output  1  high in CALC and DONE; start ignored while high.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 out1882  output  16  difference ina - inb - bin, modulo 2^16.
REQ-011 bout  output  1  final borrow; 1 iff ina < inb + bin (unsigned).
REQ-012 ovf  output  1  two's-complement overflow: ina[15] != inb[15] and out1882[15] != ina[15].

Function
REQ-013 States IDLE, CALC, DONE; IDLE--start-->CALC; CALC--(cnt == NSLICE-1)-->DONE; DONE-->IDLE unconditionally.
REQ-014 The edge sampling start in IDLE SHALL latch ina/inb/bin into operand registers, clear the slice counter cnt, and load the running borrow with bin.
REQ-015 Each CALC edge SHALL subtract slice cnt (bits cnt*SLICE+SLICE-1..cnt*SLICE, LSB slice first) with the running borrow, store the slice into an internal result register, update the borrow, and increment cnt.
REQ-016 out1882, bout, ovf SHALL update only on the edge entering DONE and SHALL hold that value until the next DONE entry or reset; partial results never appear on outputs.
REQ-017 done SHALL be high exactly in the DONE cycle, i.e. from edge NSLICE to edge NSLICE+1 after the start-sampling edge (NSLICE=4: edges 4..5).
REQ-018 Throughput: one operation per NSLICE+2 cycles; a start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-019 start, ina, inb, bin changes during CALC or DONE SHALL have no effect on the operation in flight.
REQ-020 cnt SHALL be log2(NSLICE) bits minimum and SHALL NOT wrap inside CALC.

Reset
REQ-021 rst high at an edge SHALL force IDLE, cnt=0, busy=0, done=0, out1882=0x0000, bout=0, ovf=0, operand registers 0.
REQ-022 rst during CALC or DONE SHALL abandon the operation; no done pulse SHALL follow; rst has priority over start.
REQ-023 First start after rst deassertion SHALL be accepted on the first edge where rst=0.

Structure
REQ-024 Package sub_pkg SHALL hold the state enumeration, the data width constant 16 and the default SLICE.
REQ-025 Sub-module sub_slice SHALL be a SLICE-bit combinational ripple subtractor (a, b, borrow-in -> diff, borrow-out), instantiated once and reused each cycle.
REQ-026 All storage SHALL live in sub_serial16; sub_slice SHALL contain no registers.

Verification
REQ-027 ina=0x0005, inb=0x0003, bin=0 -> out1882=0x0002, bout=0, ovf=0; done at edge 4 after start edge; busy high for 5 cycles.
REQ-028 ina=0x0000, inb=0x0001, bin=0 -> out1882=0xFFFF, bout=1, ovf=0; ina=0x1000, inb=0x0001 -> 0x0FFF, bout=0 (borrow crosses three slices).
REQ-029 ina=0x8000, inb=0x0001, bin=0 -> out1882=0x7FFF, bout=0, ovf=1; ina=0xAAAA, inb=0x5555, bin=1 -> 0x5554, bout=0, ovf=1.
REQ-030 Start with 0x0005/0x0003, then hold start=1 with ina=0xFFFF during CALC -> first done gives 0x0002; second op accepted in first IDLE cycle, done 6 cycles after first done.
REQ-031 rst pulsed at cnt=2 -> next cycle busy=0, done never asserts, out1882=0x0000, bout=0, ovf=0; new start then completes normally.

Source files
------------

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared definitions for the serial 16-bit subtractor:
//               FSM state encoding, datapath width and default slice width.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int DATA_W    = 16;  // operand / result width
    localparam int SLICE_DEF = 4;   // default bits processed per cycle

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/sub_slice.sv
`default_nettype none
// ============================================================================
// Module      : sub_slice
// Description : SLICE-bit combinational ripple-borrow subtractor.
//               diff = a - b - bin (mod 2^SLICE), bout = borrow out of MSB.
// Ports       : a    [SLICE-1:0] in  - minuend slice
//               b    [SLICE-1:0] in  - subtrahend slice
//               bin              in  - borrow into the LSB
//               diff [SLICE-1:0] out - difference slice
//               bout             out - borrow out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    always_comb begin
        logic br;
        br   = bin;
        diff = '0;
        for (int i = 0; i < SLICE; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            // borrow when a<b at this bit, or a==b with an incoming borrow
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule : sub_slice
`default_nettype wire

// File: rtl/sub_serial16.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial16
// Description : Serial 16-bit subtractor. One SLICE-bit slice is subtracted
//               per CALC cycle (LSB slice first) through a single reused
//               sub_slice instance; results are published on entering DONE.
// Ports       : clk      in  - clock, rising edge
//               rst      in  - synchronous active-high reset
//               start    in  - operation request (sampled in IDLE only)
//               ina[15:0] in - minuend
//               inb[15:0] in - subtrahend
//               bin      in  - borrow-in
//               busy     out - high in CALC and DONE
//               done     out - one-cycle result-valid pulse
//               out1882[15:0] out - ina - inb - bin mod 2^16
//               bout     out - final borrow
//               ovf      out - two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module sub_serial16
    import sub_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] ina,
    input  logic [DATA_W-1:0] inb,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out1882,
    output logic              bout,
    output logic              ovf
);

    localparam int NSLICE = DATA_W / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                borrow_q, borrow_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                bout_q, bout_d;
    logic                ovf_q, ovf_d;

    logic [IDX_W-1:0]    w_lsb;
    logic [SLICE-1:0]    w_slice_diff;
    logic                w_slice_bout;
    logic [DATA_W-1:0]   w_res_next;

    assign w_lsb = IDX_W'(cnt_q) * IDX_W'(SLICE);

    sub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (a_q[w_lsb +: SLICE]),
        .b    (b_q[w_lsb +: SLICE]),
        .bin  (borrow_q),
        .diff (w_slice_diff),
        .bout (w_slice_bout)
    );

    // Result register with the current slice merged in; on the last slice
    // this is the complete difference that gets published.
    always_comb begin
        w_res_next                   = res_q;
        w_res_next[w_lsb +: SLICE]   = w_slice_diff;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        res_d    = res_q;
        out_d    = out_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = ina;
                    b_d      = inb;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                res_d    = w_res_next;
                borrow_d = w_slice_bout;
                if (cnt_q == CNT_LAST) begin
                    // counter holds here so it never wraps inside CALC
                    state_d = ST_DONE;
                    out_d   = w_res_next;
                    bout_d  = w_slice_bout;
                    ovf_d   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                              (w_res_next[DATA_W-1] != a_q[DATA_W-1]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            out_q    <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            out_q    <= out_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign out1882 = out_q;
    assign bout    = bout_q;
    assign ovf     = ovf_q;

endmodule : sub_serial16
`default_nettype wire

// File: tb/tb_sub_serial16.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_serial16
// Description : Directed self-checking bench for sub_serial16 (SLICE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_serial16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] ina;
    logic [15:0] inb;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] out1882;
    logic        bout;
    logic        ovf;

    int total;
    int bad;

    sub_serial16 #(
        .SLICE (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ina     (ina),
        .inb     (inb),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .out1882 (out1882),
        .bout    (bout),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits up to 'limit' edges for done; returns edges waited.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Full operation: start sampled at the next edge, then checks latency,
    // busy window and published results.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input logic [15:0] eo, input logic ebo,
                         input logic eov);
        int n;
        @(negedge clk);
        ina = a; inb = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ina = 16'h1234; inb = 16'h4321; bin = ~bi;   // must not disturb op
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        wait_done(20, n);
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_out"}, 32'(out1882), 32'(eo));
        chk({tag, "_bout"}, 32'(bout), 32'(ebo));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
        chk({tag, "_busyD"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, 32'(out1882), 32'(eo));
    endtask

    initial begin
        int n;
        int gap;
        int seen;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        ina   = '0;
        inb   = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {27'd0, busy, done, bout, ovf, 1'b0}, 32'd0);
        chk("rst_out", 32'(out1882), 32'd0);

        // rst has priority over start
        @(negedge clk);
        start = 1'b1; ina = 16'h0005; inb = 16'h0003;
        @(posedge clk); #1;
        chk("rst_prio", 32'(busy), 32'd0);
        // first start after release accepted on the first rst=0 edge
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_accept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(20, n);
        chk("rel_lat", 32'(n), 32'd4);
        chk("rel_out", 32'(out1882), 32'h0002);
        @(posedge clk); #1;

        do_op("t5m3",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        do_op("t0m1",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        do_op("t1000",  16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        do_op("t8000",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        do_op("tAAAA",  16'hAAAA, 16'h5555, 1'b1, 16'h5554, 1'b0, 1'b1);
        do_op("tbin",   16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_op("t7FFF",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // back-to-back: start held high, inputs changed during CALC
        @(negedge clk);
        ina = 16'h0005; inb = 16'h0003; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        ina = 16'hFFFF;
        wait_done(20, n);
        chk("b2b_lat1", 32'(n), 32'd4);
        chk("b2b_out1", 32'(out1882), 32'h0002);
        gap = 0;
        @(posedge clk); #1; gap++;
        while (!done && gap < 20) begin
            @(posedge clk); #1; gap++;
        end
        start = 1'b0;
        chk("b2b_gap", 32'(gap), 32'd6);
        chk("b2b_out2", 32'(out1882), 32'hFFFC);
        chk("b2b_bout2", {30'd0, bout, ovf}, 32'd0);
        @(posedge clk); #1;

        // reset in the middle of CALC (cnt==2)
        @(negedge clk);
        ina = 16'h8000; inb = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_busy", {30'd0, busy, done}, 32'd0);
        chk("mid_out", 32'(out1882), 32'd0);
        chk("mid_flags", {30'd0, bout, ovf}, 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("mid_nodone", 32'(seen), 32'd0);
        do_op("post", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sub_serial16
`default_nettype wire
